// File: rtl/tea_pkg.sv
// TEA shared definitions: key-schedule constant, FSM states, decipher start sum.
package tea_pkg;

    localparam logic [31:0] TEA_DELTA   = 32'h9e3779b9;
    localparam logic [31:0] TEA_DEC_SUM = 32'hC6EF3720;

    typedef enum logic [2:0] {
        IDLE,
        ADD_DELTA,
        V0_TERMS,
        V0_ADD,
        V1_TERMS,
        V1_ADD,
        DONE
    } tea_state_e;

endpackage

// File: rtl/tea_round_f.sv
// TEA Feistel function: ((v<<4)+ka) ^ (v+sum) ^ ((v>>5)+kb), all mod 2^W.
module tea_round_f
    import tea_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 32
) (
    input  logic [WORD_SIZE-1:0] v_i,
    input  logic [WORD_SIZE-1:0] sum_i,
    input  logic [WORD_SIZE-1:0] ka_i,
    input  logic [WORD_SIZE-1:0] kb_i,
    output logic [WORD_SIZE-1:0] f_o
);

    assign f_o = ((v_i << 4) + ka_i)
               ^ (v_i + sum_i)
               ^ ((v_i >> 5) + kb_i);

endmodule

// File: rtl/tea_encipher.sv
// Multi-cycle TEA encipher. Define TEA_ENC_MERGED_ROUND_EN for the
// 3-cycle round (F computed combinationally) instead of the 5-cycle round.
module tea_encipher
    import tea_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = 32,
    parameter logic [31:0] DELTA        = TEA_DELTA,
    parameter int unsigned ROUND_NUMBER = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iStart,
    input  logic [WORD_SIZE-1:0] iV0,
    input  logic [WORD_SIZE-1:0] iV1,
    input  logic [WORD_SIZE-1:0] iK0,
    input  logic [WORD_SIZE-1:0] iK1,
    input  logic [WORD_SIZE-1:0] iK2,
    input  logic [WORD_SIZE-1:0] iK3,
    output logic [WORD_SIZE-1:0] oC0,
    output logic [WORD_SIZE-1:0] oC1,
    output logic                 oBusy,
    output logic                 oDone
);

    localparam int unsigned CW = (ROUND_NUMBER > 1) ? $clog2(ROUND_NUMBER) : 1;
    localparam logic [CW-1:0] LAST = CW'(ROUND_NUMBER - 1);
    localparam logic [WORD_SIZE-1:0] DELTA_W = WORD_SIZE'(DELTA);

    tea_state_e state_q;
    logic [WORD_SIZE-1:0] c0_q, c1_q, sum_q;
    logic [WORD_SIZE-1:0] k0_q, k1_q, k2_q, k3_q;
    logic [CW-1:0] cnt_q;
    logic busy_q, done_q;
    logic [WORD_SIZE-1:0] f0, f1;

`ifdef TEA_ENC_MERGED_ROUND_EN
    localparam tea_state_e V0_FIRST = V0_ADD;
    localparam tea_state_e V1_FIRST = V1_ADD;

    tea_round_f #(.WORD_SIZE(WORD_SIZE)) u_f0 (
        .v_i(c1_q), .sum_i(sum_q), .ka_i(k0_q), .kb_i(k1_q), .f_o(f0)
    );
    tea_round_f #(.WORD_SIZE(WORD_SIZE)) u_f1 (
        .v_i(c0_q), .sum_i(sum_q), .ka_i(k2_q), .kb_i(k3_q), .f_o(f1)
    );
`else
    localparam tea_state_e V0_FIRST = V0_TERMS;
    localparam tea_state_e V1_FIRST = V1_TERMS;

    // Terms are registered one cycle ahead; both halves share the aux regs.
    logic [WORD_SIZE-1:0] aux1_q, aux2_q, aux3_q;
    assign f0 = aux1_q ^ aux2_q ^ aux3_q;
    assign f1 = f0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            c0_q    <= '0;
            c1_q    <= '0;
            sum_q   <= '0;
            k0_q    <= '0;
            k1_q    <= '0;
            k2_q    <= '0;
            k3_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifndef TEA_ENC_MERGED_ROUND_EN
            aux1_q  <= '0;
            aux2_q  <= '0;
            aux3_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (iStart) begin
                        c0_q    <= iV0;
                        c1_q    <= iV1;
                        k0_q    <= iK0;
                        k1_q    <= iK1;
                        k2_q    <= iK2;
                        k3_q    <= iK3;
                        sum_q   <= '0;
                        cnt_q   <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ADD_DELTA;
                    end
                end
                ADD_DELTA: begin
                    sum_q   <= sum_q + DELTA_W;
                    state_q <= V0_FIRST;
                end
`ifndef TEA_ENC_MERGED_ROUND_EN
                V0_TERMS: begin
                    aux1_q  <= (c1_q << 4) + k0_q;
                    aux2_q  <= c1_q + sum_q;
                    aux3_q  <= (c1_q >> 5) + k1_q;
                    state_q <= V0_ADD;
                end
                V1_TERMS: begin
                    aux1_q  <= (c0_q << 4) + k2_q;
                    aux2_q  <= c0_q + sum_q;
                    aux3_q  <= (c0_q >> 5) + k3_q;
                    state_q <= V1_ADD;
                end
`endif
                V0_ADD: begin
                    c0_q    <= c0_q + f0;
                    state_q <= V1_FIRST;
                end
                V1_ADD: begin
                    c1_q    <= c1_q + f1;
                    cnt_q   <= cnt_q + CW'(1);
                    state_q <= (cnt_q == LAST) ? DONE : ADD_DELTA;
                end
                DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    if (!iStart) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oC0   = c0_q;
    assign oC1   = c1_q;
    assign oBusy = busy_q;
    assign oDone = done_q;

endmodule

// File: tb/tb_tea_encipher.sv
// Self-checking bench for tea_encipher against a plain-arithmetic TEA model.
// Honors TEA_ENC_MERGED_ROUND_EN for the expected latency.
module tb_tea_encipher;

`ifdef TEA_ENC_MERGED_ROUND_EN
    localparam int LAT = 97;
`else
    localparam int LAT = 161;
`endif
    localparam logic [31:0] DELTA = 32'h9e3779b9;

    logic clk = 1'b0;
    logic rst;
    logic iStart;
    logic [31:0] iV0, iV1, iK0, iK1, iK2, iK3;
    logic [31:0] oC0, oC1;
    logic oBusy, oDone;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tea_encipher dut (
        .clk(clk), .rst(rst), .iStart(iStart),
        .iV0(iV0), .iV1(iV1),
        .iK0(iK0), .iK1(iK1), .iK2(iK2), .iK3(iK3),
        .oC0(oC0), .oC1(oC1), .oBusy(oBusy), .oDone(oDone)
    );

    function automatic logic [63:0] tea_enc(input logic [31:0] v0, v1,
                                            input logic [31:0] k0, k1, k2, k3);
        logic [31:0] s;
        s = 32'h0;
        for (int r = 0; r < 32; r++) begin
            s  = s + DELTA;
            v0 = v0 + ((((v1 << 4) + k0) ^ (v1 + s)) ^ ((v1 >> 5) + k1));
            v1 = v1 + ((((v0 << 4) + k2) ^ (v0 + s)) ^ ((v0 >> 5) + k3));
        end
        return {v0, v1};
    endfunction

    function automatic logic [63:0] tea_dec(input logic [31:0] v0, v1,
                                            input logic [31:0] k0, k1, k2, k3);
        logic [31:0] s;
        s = 32'hC6EF3720;
        for (int r = 0; r < 32; r++) begin
            v1 = v1 - ((((v0 << 4) + k2) ^ (v0 + s)) ^ ((v0 >> 5) + k3));
            v0 = v0 - ((((v1 << 4) + k0) ^ (v1 + s)) ^ ((v1 >> 5) + k1));
            s  = s - DELTA;
        end
        return {v0, v1};
    endfunction

    // Called one step after an edge; the next edge is the accept edge (0).
    task automatic run_op(input logic [31:0] v0, v1, k0, k1, k2, k3,
                          output int lat, output logic [31:0] c0, c1,
                          output logic d0, b0);
        iV0 = v0; iV1 = v1;
        iK0 = k0; iK1 = k1; iK2 = k2; iK3 = k3;
        iStart = 1'b1;
        lat = -1;
        d0 = 1'bx;
        b0 = 1'bx;
        for (int i = 0; i < LAT + 20; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                d0 = oDone;
                b0 = oBusy;
            end
            if (oDone === 1'b1 && i > 0) begin
                lat = i;
                break;
            end
        end
        c0 = oC0;
        c1 = oC1;
    endtask

    task automatic release_start();
        iStart = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_result(input string name, input logic [31:0] v0, v1,
                                k0, k1, k2, k3, input int lat,
                                input logic [31:0] c0, c1);
        logic [63:0] exp;
        logic [63:0] back;
        exp  = tea_enc(v0, v1, k0, k1, k2, k3);
        back = tea_dec(c0, c1, k0, k1, k2, k3);
        total++;
        if ({c0, c1} !== exp) begin
            bad++;
            $display("FAIL %s cipher: got %h want %h", name, {c0, c1}, exp);
        end
        total++;
        if (back !== {v0, v1}) begin
            bad++;
            $display("FAIL %s roundtrip: got %h want %h", name, back, {v0, v1});
        end
        total++;
        if (lat !== LAT) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, LAT);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({oC0, oC1, oBusy, oDone} !== 66'h0) begin
            bad++;
            $display("FAIL reset_state: got %h want 0", {oC0, oC1, oBusy, oDone});
        end
    endtask

    task automatic test_known_vector();
        int lat;
        logic [31:0] c0, c1;
        logic d0, b0;
        run_op(0, 0, 0, 0, 0, 0, lat, c0, c1, d0, b0);
        total++;
        if ({c0, c1} !== 64'h41EA3A0A_94BAA940) begin
            bad++;
            $display("FAIL zero_vector: got %h want 41ea3a0a94baa940", {c0, c1});
        end
        total++;
        if (lat !== LAT) begin
            bad++;
            $display("FAIL zero_latency: got %0d want %0d", lat, LAT);
        end
        total++;
        if ({d0, b0} !== 2'b01) begin
            bad++;
            $display("FAIL accept_flags: got done,busy=%b want 01", {d0, b0});
        end
        release_start();
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] v[6];
        logic [31:0] c0, c1;
        logic d0, b0;
        for (int n = 0; n < 4; n++) begin
            for (int j = 0; j < 6; j++) v[j] = $urandom;
            if (n == 3) begin
                v[0] = 32'hFFFFFFFF; v[1] = 32'hFFFFFFFF;
                v[2] = 32'hFFFFFFFF; v[5] = 32'hFFFFFFFF;
            end
            run_op(v[0], v[1], v[2], v[3], v[4], v[5], lat, c0, c1, d0, b0);
            check_result("random", v[0], v[1], v[2], v[3], v[4], v[5],
                         lat, c0, c1);
            release_start();
        end
    endtask

    task automatic test_input_change();
        int lat;
        lat = -1;
        iV0 = 0; iV1 = 0; iK0 = 0; iK1 = 0; iK2 = 0; iK3 = 0;
        iStart = 1'b1;
        for (int i = 0; i < LAT + 20; i++) begin
            @(posedge clk); #1;
            if (i == 50) begin
                iV0 = $urandom;
                iK0 = $urandom | 32'h1;
                iStart = 1'b0;
            end
            if (i == 51) iStart = 1'b1;
            if (oDone === 1'b1 && i > 0) begin
                lat = i;
                break;
            end
        end
        total++;
        if ({oC0, oC1} !== 64'h41EA3A0A_94BAA940 || lat !== LAT) begin
            bad++;
            $display("FAIL input_change: got %h lat %0d want 41ea3a0a94baa940 lat %0d",
                     {oC0, oC1}, lat, LAT);
        end
        release_start();
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [31:0] c0, c1;
        logic d0, b0;
        logic [31:0] a, b;
        iV0 = $urandom; iV1 = $urandom;
        iK0 = $urandom; iK1 = $urandom; iK2 = $urandom; iK3 = $urandom;
        iStart = 1'b1;
        for (int i = 0; i <= 80; i++) begin
            @(posedge clk); #1;
        end
        total++;
        if (oBusy !== 1'b1) begin
            bad++;
            $display("FAIL busy_mid: got %b want 1", oBusy);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({oC0, oC1, oBusy, oDone} !== 66'h0) begin
            bad++;
            $display("FAIL reset_mid: got %h want 0", {oC0, oC1, oBusy, oDone});
        end
        iStart = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        a = $urandom;
        b = $urandom;
        run_op(a, b, 32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210,
               lat, c0, c1, d0, b0);
        check_result("after_reset", a, b, 32'h01234567, 32'h89abcdef,
                     32'hfedcba98, 32'h76543210, lat, c0, c1);
        release_start();
    endtask

    task automatic test_reset_start();
        int lat;
        logic [31:0] c0, c1;
        logic d0, b0;
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        iV0 = a; iV1 = b;
        iStart = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(a, b, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
               lat, c0, c1, d0, b0);
        check_result("start_at_reset", a, b, 32'h11111111, 32'h22222222,
                     32'h33333333, 32'h44444444, lat, c0, c1);
        release_start();
    endtask

    task automatic test_hold_start();
        int lat;
        logic [31:0] c0, c1, n0, n1;
        logic d0, b0;
        logic held_ok;
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        run_op(a, b, 32'hdeadbeef, 32'h0, 32'hcafef00d, 32'h5a5a5a5a,
               lat, c0, c1, d0, b0);
        check_result("hold_first", a, b, 32'hdeadbeef, 32'h0, 32'hcafef00d,
                     32'h5a5a5a5a, lat, c0, c1);
        held_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) iV0 = ~iV0;
            @(posedge clk); #1;
            if (!(oDone === 1'b1 && oBusy === 1'b0 && oC0 === c0 && oC1 === c1))
                held_ok = 1'b0;
        end
        total++;
        if (held_ok !== 1'b1) begin
            bad++;
            $display("FAIL hold_no_restart: got done=%b busy=%b c=%h want 1 0 %h",
                     oDone, oBusy, {oC0, oC1}, {c0, c1});
        end
        release_start();
        total++;
        if ({oDone, oBusy} !== 2'b10) begin
            bad++;
            $display("FAIL idle_done_held: got done,busy=%b want 10", {oDone, oBusy});
        end
        run_op(b, a, 32'h5a5a5a5a, 32'hcafef00d, 32'h0, 32'hdeadbeef,
               lat, n0, n1, d0, b0);
        total++;
        if ({d0, b0} !== 2'b01) begin
            bad++;
            $display("FAIL rerun_accept: got done,busy=%b want 01", {d0, b0});
        end
        check_result("hold_second", b, a, 32'h5a5a5a5a, 32'hcafef00d, 32'h0,
                     32'hdeadbeef, lat, n0, n1);
        release_start();
    endtask

    initial begin
        rst = 1'b1;
        iStart = 1'b0;
        iV0 = 0; iV1 = 0; iK0 = 0; iK1 = 0; iK2 = 0; iK3 = 0;
        #2;
        test_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        test_known_vector();
        test_random();
        test_input_change();
        test_reset_mid();
        test_reset_start();
        test_hold_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
